fifo_rptr_empty_p: RTL and testbench
====================================

FIFO_RPTR_EMPTY_P -- requirements
Module: fifo_rptr_empty_p

Interface
REQ-001 SHALL have parameter ADDR_W, default 4; address width, FIFO depth = 2**ADDR_W.
REQ-002 SHALL have parameter AEMPTY_TH, default 2; almost-empty threshold in entries, legal range 0..2**ADDR_W-1.
REQ-003 SHALL have port rclk  input  1  read-domain clock, all state on rising edge.
REQ-004 SHALL have port rrst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rinc  input  1  read request; pop one entry this cycle.
REQ-006 SHALL have port rq2_wptr  input  ADDR_W+1  write pointer, Gray-coded, already 2-flop synchronised into rclk.
REQ-007 SHALL have port ruf_clr  input  1  clears sticky underflow flag.
REQ-008 SHALL have port raddr  output  ADDR_W  binary RAM read address.
REQ-009 SHALL have port rptr  output  ADDR_W+1  Gray read pointer for the write domain.
REQ-010 SHALL have port rempty  output  1  FIFO empty, registered.
REQ-011 SHALL have port raempty  output  1  almost empty, registered.
REQ-012 SHALL have port rlevel  output  ADDR_W+1  fill level seen from read side, registered.
REQ-013 SHALL have port runderflow  output  1  sticky: read attempted while empty.

Function
REQ-014 SHALL hold a binary read counter rbin (ADDR_W+1 bits); rbin_next = rbin + (rinc & ~rempty), modulo 2**(ADDR_W+1).
REQ-015 SHALL drive raddr = rbin[ADDR_W-1:0] combinationally from the registered counter; wrap from 2**ADDR_W-1 to 0 with MSB toggle.
REQ-016 SHALL register rptr = bin2gray(rbin_next) every cycle; rptr changes by at most one bit per cycle.
REQ-017 SHALL register rempty = (bin2gray(rbin_next) == rq2_wptr); pop of last entry asserts rempty the following cycle.
REQ-018 SHALL deassert rempty one rclk after rq2_wptr differs from the Gray read pointer (total write-to-visible latency = 2 sync flops + 1).
REQ-019 SHALL compute rlevel_next = gray2bin(rq2_wptr) - rbin_next modulo 2**(ADDR_W+1) and register it; full FIFO gives 2**ADDR_W.
REQ-020 SHALL register raempty = (rlevel_next <= AEMPTY_TH).
REQ-021 SHALL ignore rinc while rempty=1: counter, raddr, rptr unchanged.
REQ-022 SHALL set runderflow on the edge after any cycle with rinc=1 and rempty=1; hold until ruf_clr=1.
REQ-023 SHALL give set priority when underflow and ruf_clr coincide (runderflow stays 1).
REQ-024 SHALL treat simultaneous rinc and rq2_wptr change as independent: both applied in the same cycle's next-state.

Reset
REQ-025 SHALL on rrst_n=0 immediately force rbin=0, rptr=0, rempty=1, raempty=1, rlevel=0, runderflow=0, regardless of rclk.
REQ-026 SHALL resume on the first rclk edge after rrst_n deassertion; reset mid-pop discards that pop.

Configuration
REQ-027 SHALL compile level/almost-empty logic only when macro FIFO_RLEVEL_EN is defined.
REQ-028 SHALL, without FIFO_RLEVEL_EN, keep all ports, drive rlevel constant 0, raempty equal to rempty, and omit the gray2bin subtractor.

Structure
REQ-029 SHALL take bin2gray/gray2bin functions and ADDR_W default constant from shared package fifo_pkg.
REQ-030 SHALL instantiate one sub-module fifo_gray2bin (parametrised width) for rq2_wptr conversion, present only under FIFO_RLEVEL_EN.

Verification (ADDR_W=4, AEMPTY_TH=2, FIFO_RLEVEL_EN defined)
REQ-031 SHALL check reset: rrst_n low mid-cycle -> all outputs at reset values before next rclk edge, rempty=1, rptr=5'b00000.
REQ-032 SHALL check fill/drain: rq2_wptr stepped to Gray(3) -> rempty=0, rlevel=3, raempty=0 after 1 edge; 3 pops -> raddr 0,1,2, rlevel 2,1,0, rempty=1 after third pop.
REQ-033 SHALL check underflow: rinc=1 while rempty=1 -> rptr unchanged, runderflow=1 next edge; ruf_clr with rinc=1, rempty=1 same cycle -> runderflow stays 1.
REQ-034 SHALL check wrap: 40 write/pop pairs -> raddr wraps 15->0, rptr MSB toggles at count 16 and 32, single-bit Gray change every step.
REQ-035 SHALL check full level: rq2_wptr=Gray(16) with rbin=0 -> rlevel=16, raempty=0; macro undefined -> rlevel=0, raempty tracks rempty.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: default address width and Gray/binary conversions.
// Helpers work on a 32-bit container; callers zero-extend in and truncate out.
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int PTR_MAX_W  = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

  function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
    ptr_wide_t b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rptr_empty_p_if.sv
// Read-side FIFO pointer bundle: requests from the reader, pointer/flags back from the block.
interface fifo_rptr_empty_p_if
  import fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              rinc;
  logic [ADDR_W:0]   rq2_wptr;
  logic              ruf_clr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   rptr;
  logic              rempty;
  logic              raempty;
  logic [ADDR_W:0]   rlevel;
  logic              runderflow;

  modport master (
    output rinc, rq2_wptr, ruf_clr,
    input  raddr, rptr, rempty, raempty, rlevel, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr, ruf_clr,
    output raddr, rptr, rempty, raempty, rlevel, runderflow
  );
endinterface

// File: rtl/fifo_gray2bin.sv
// Gray-to-binary converter of parametrised width, used for the synchronised write pointer.
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int W = ADDR_W_DEF + 1
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);
  assign o_bin = W'(gray2bin(ptr_wide_t'(i_gray)));
endmodule

// File: rtl/fifo_rptr_empty_p.sv
// FIFO read pointer, empty/almost-empty flags and sticky underflow for the read clock domain.
// Optional macro FIFO_RLEVEL_EN adds the fill-level and almost-empty computation.
module fifo_rptr_empty_p
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AEMPTY_TH = 2
) (
  input  logic               rclk,
  input  logic               rrst_n,
  fifo_rptr_empty_p_if.slave bus
);
  logic [ADDR_W:0] r_rbin;
  logic [ADDR_W:0] r_rptr;
  logic            r_rempty;
  logic            r_raempty;
  logic [ADDR_W:0] r_rlevel;
  logic            r_runderflow;

  logic [ADDR_W:0] w_rbin_next;
  logic [ADDR_W:0] w_rgray_next;
  logic            w_rempty_next;
  logic            w_runderflow_next;
  logic [ADDR_W:0] w_rlevel_next;
  logic            w_raempty_next;

  // A pop only advances the counter while the registered flag says data is present.
  assign w_rbin_next   = r_rbin + {{ADDR_W{1'b0}}, (bus.rinc & ~r_rempty)};
  assign w_rgray_next  = (ADDR_W+1)'(bin2gray(ptr_wide_t'(w_rbin_next)));
  assign w_rempty_next = (w_rgray_next == bus.rq2_wptr);

`ifdef FIFO_RLEVEL_EN
  localparam logic [ADDR_W:0] AEMPTY_TH_W = (ADDR_W+1)'(AEMPTY_TH);
  logic [ADDR_W:0] w_wbin;

  fifo_gray2bin #(
    .W (ADDR_W + 1)
  ) u_wptr_g2b (
    .i_gray (bus.rq2_wptr),
    .o_bin  (w_wbin)
  );

  assign w_rlevel_next  = w_wbin - w_rbin_next;
  assign w_raempty_next = (w_rlevel_next <= AEMPTY_TH_W);
`else
  assign w_rlevel_next  = {(ADDR_W+1){1'b0}};
  assign w_raempty_next = w_rempty_next;
`endif

  // Underflow is sticky; a new violation wins over a simultaneous clear.
  always_comb begin
    w_runderflow_next = r_runderflow;
    if (bus.rinc && r_rempty) begin
      w_runderflow_next = 1'b1;
    end else if (bus.ruf_clr) begin
      w_runderflow_next = 1'b0;
    end else begin
      w_runderflow_next = r_runderflow;
    end
  end

  // Read-side state register: counter, Gray pointer, flags and level move together.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_rbin       <= {(ADDR_W+1){1'b0}};
      r_rptr       <= {(ADDR_W+1){1'b0}};
      r_rempty     <= 1'b1;
      r_raempty    <= 1'b1;
      r_rlevel     <= {(ADDR_W+1){1'b0}};
      r_runderflow <= 1'b0;
    end else begin
      r_rbin       <= w_rbin_next;
      r_rptr       <= w_rgray_next;
      r_rempty     <= w_rempty_next;
      r_raempty    <= w_raempty_next;
      r_rlevel     <= w_rlevel_next;
      r_runderflow <= w_runderflow_next;
    end
  end

  assign bus.raddr      = r_rbin[ADDR_W-1:0];
  assign bus.rptr       = r_rptr;
  assign bus.rempty     = r_rempty;
  assign bus.raempty    = r_raempty;
  assign bus.rlevel     = r_rlevel;
  assign bus.runderflow = r_runderflow;
endmodule

// File: tb/tb_fifo_rptr_empty_p.sv
// Bench for fifo_rptr_empty_p (ADDR_W=4, AEMPTY_TH=2): directed table, corner sequences,
// and random traffic against an occupancy-count reference model.
module tb_fifo_rptr_empty_p;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  fifo_rptr_empty_p_if #(.ADDR_W(4)) bus ();

  fifo_rptr_empty_p #(
    .ADDR_W    (4),
    .AEMPTY_TH (2)
  ) dut (
    .rclk   (clk),
    .rrst_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts of entries written and read, plain integers.
  int         rd_cnt;
  int         wr_cnt;
  logic       exp_empty;
  logic       exp_aempty;
  logic       exp_uf;
  logic [4:0] exp_level;
  logic [4:0] exp_rptr;
  logic [3:0] exp_raddr;

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    rd_cnt     = 0;
    wr_cnt     = 0;
    exp_empty  = 1'b1;
    exp_aempty = 1'b1;
    exp_uf     = 1'b0;
    exp_level  = 5'd0;
    exp_rptr   = 5'd0;
    exp_raddr  = 4'd0;
  endtask

  task automatic model_update(input logic inc, input int w, input logic clr);
    int lvl;
    if (inc && exp_empty) exp_uf = 1'b1;
    else if (clr) exp_uf = 1'b0;
    if (inc && !exp_empty) rd_cnt++;
    wr_cnt = w;
    lvl = w - rd_cnt;
    exp_empty = (lvl == 0);
`ifdef FIFO_RLEVEL_EN
    exp_level  = 5'(lvl);
    exp_aempty = (lvl <= 2);
`else
    exp_level  = 5'd0;
    exp_aempty = exp_empty;
`endif
    exp_rptr  = gray5(rd_cnt);
    exp_raddr = 4'(rd_cnt % 16);
  endtask

  task automatic step(input logic inc, input int w, input logic clr);
    @(negedge clk);
    bus.rinc     = inc;
    bus.rq2_wptr = gray5(w);
    bus.ruf_clr  = clr;
    @(posedge clk);
    model_update(inc, w, clr);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".raddr"},      32'(bus.raddr),      32'(exp_raddr));
    chk({tag, ".rptr"},       32'(bus.rptr),       32'(exp_rptr));
    chk({tag, ".rempty"},     32'(bus.rempty),     32'(exp_empty));
    chk({tag, ".raempty"},    32'(bus.raempty),    32'(exp_aempty));
    chk({tag, ".rlevel"},     32'(bus.rlevel),     32'(exp_level));
    chk({tag, ".runderflow"}, 32'(bus.runderflow), 32'(exp_uf));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".raddr"},      32'(bus.raddr),      32'd0);
    chk({tag, ".rptr"},       32'(bus.rptr),       32'd0);
    chk({tag, ".rempty"},     32'(bus.rempty),     32'd1);
    chk({tag, ".raempty"},    32'(bus.raempty),    32'd1);
    chk({tag, ".rlevel"},     32'(bus.rlevel),     32'd0);
    chk({tag, ".runderflow"}, 32'(bus.runderflow), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.rinc     = 1'b0;
    bus.rq2_wptr = 5'd0;
    bus.ruf_clr  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       rinc;
    int         wr;
    logic       clr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       empty;
    logic [4:0] level;
    logic       aempty;
    logic       uf;
  } vec_t;

  vec_t tv [10];

  initial begin
    logic [4:0] prev_rptr;
    logic       want_aempty;
    logic [4:0] want_level;
    int         w;
    errors = 0;
    checks = 0;

    // Directed fill/drain/underflow vectors; expectations are full-feature values.
    tv[0] = '{1'b0, 3, 1'b0, 4'd0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0};
    tv[1] = '{1'b1, 3, 1'b0, 4'd1, 5'd1, 1'b0, 5'd2, 1'b1, 1'b0};
    tv[2] = '{1'b1, 3, 1'b0, 4'd2, 5'd3, 1'b0, 5'd1, 1'b1, 1'b0};
    tv[3] = '{1'b1, 3, 1'b0, 4'd3, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0};
    tv[4] = '{1'b1, 3, 1'b0, 4'd3, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1};
    tv[5] = '{1'b0, 3, 1'b1, 4'd3, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0};
    tv[6] = '{1'b1, 3, 1'b1, 4'd3, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1};
    tv[7] = '{1'b0, 3, 1'b0, 4'd3, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1};
    tv[8] = '{1'b1, 4, 1'b0, 4'd3, 5'd2, 1'b0, 5'd1, 1'b1, 1'b1};
    tv[9] = '{1'b1, 5, 1'b1, 4'd4, 5'd6, 1'b0, 5'd1, 1'b1, 1'b0};

    rst_n        = 1'b0;
    bus.rinc     = 1'b0;
    bus.rq2_wptr = 5'd0;
    bus.ruf_clr  = 1'b0;
    model_reset();
    #12;
    check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tv[i].rinc, tv[i].wr, tv[i].clr);
`ifdef FIFO_RLEVEL_EN
      want_level  = tv[i].level;
      want_aempty = tv[i].aempty;
`else
      want_level  = 5'd0;
      want_aempty = tv[i].empty;
`endif
      chk($sformatf("vec%0d.raddr", i),      32'(bus.raddr),      32'(tv[i].raddr));
      chk($sformatf("vec%0d.rptr", i),       32'(bus.rptr),       32'(tv[i].rptr));
      chk($sformatf("vec%0d.rempty", i),     32'(bus.rempty),     32'(tv[i].empty));
      chk($sformatf("vec%0d.rlevel", i),     32'(bus.rlevel),     32'(want_level));
      chk($sformatf("vec%0d.raempty", i),    32'(bus.raempty),    32'(want_aempty));
      chk($sformatf("vec%0d.runderflow", i), 32'(bus.runderflow), 32'(tv[i].uf));
    end

    // Asynchronous reset in the middle of a cycle, with a pop request pending.
    @(posedge clk);
    #2;
    bus.rinc = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    bus.rinc = 1'b0;
    rst_n    = 1'b1;
    model_reset();

    // Wrap: one write and one pop per cycle for 40 cycles.
    step(1'b0, 1, 1'b0);
    check_model("wrap_pre");
    prev_rptr = bus.rptr;
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, k + 1, 1'b0);
      check_model($sformatf("wrap%0d", k));
      chk($sformatf("wrap%0d.gray1", k), 32'($countones(bus.rptr ^ prev_rptr)), 32'd1);
      chk($sformatf("wrap%0d.msb", k), 32'(bus.rptr[4]), 32'((k / 16) % 2));
      prev_rptr = bus.rptr;
    end

    // Full FIFO seen from a read counter at zero.
    do_reset();
    step(1'b0, 16, 1'b0);
    check_model("full");

    // Random traffic from the full state, never exceeding the depth.
    for (int n = 0; n < 300; n++) begin
      w = wr_cnt;
      if ((wr_cnt + 1 - rd_cnt) <= 16 && $urandom_range(0, 1) == 1) w = wr_cnt + 1;
      step(1'($urandom_range(0, 1)), w, ($urandom_range(0, 7) == 0));
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
